// File: rtl/sti_dac_pkg.sv
// Shared types and helpers for the serial-transmit / DAC-memory block.
package sti_dac_pkg;

  typedef enum logic [1:0] {
    LEN8  = 2'd0,
    LEN16 = 2'd1,
    LEN24 = 2'd2,
    LEN32 = 2'd3
  } len_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_FILL,
    ST_FIN
  } sti_state_e;

  localparam int unsigned PIX_W = 8;

  // Frame length in bits: 8 * (pi_length + 1).
  function automatic logic [5:0] frame_len(input logic [1:0] len);
    return {1'b0, len, 3'b000} + 6'd8;
  endfunction

endpackage

// File: rtl/sti_dac_multibank_if.sv
// Parallel-input handshake bus: producer drives words, block answers with pi_ready.
interface sti_dac_multibank_if;
  logic        load;
  logic        pi_ready;
  logic [15:0] pi_data;
  logic [1:0]  pi_length;
  logic        pi_fill;
  logic        pi_msb;
  logic        pi_low;
  logic        pi_end;

  modport master (
    output load, pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end,
    input  pi_ready
  );

  modport slave (
    input  load, pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end,
    output pi_ready
  );
endinterface

// File: rtl/oem_pixel_router.sv
// Packs the serial stream into 8-bit pixels and routes them checkerboard-style
// into odd/even memory banks; zero-fills the remaining space on request.
module oem_pixel_router
  import sti_dac_pkg::*;
#(
  parameter int unsigned BANKS   = 4,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned ROW_PIX = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bit_valid,
  input  logic              bit_data,
  input  logic              fill_en,
  output logic [PIX_W-1:0]  oem_dataout,
  output logic [ADDR_W-1:0] oem_addr,
  output logic [BANKS-1:0]  odd_wr,
  output logic [BANKS-1:0]  even_wr,
  output logic              oem_finish,
  output logic              full
);

  localparam int unsigned BANK_BITS = (BANKS > 1) ? $clog2(BANKS) : 0;
  localparam int unsigned P_W       = ADDR_W + 1 + BANK_BITS + 1;
  localparam int unsigned TOTAL     = BANKS << (ADDR_W + 1);
  localparam int unsigned ROW_B     = $clog2(ROW_PIX);

  logic [P_W-1:0]   pix_idx;
  logic [6:0]       shreg;
  logic [2:0]       bcnt;
  logic             data_wr;
  logic             fill_wr;
  logic             odd_sel;
  logic [BANKS-1:0] bank_oh;
  logic [PIX_W-1:0] pix_next;

  always_comb begin
    full     = (pix_idx == P_W'(TOTAL));
    data_wr  = bit_valid && (bcnt == 3'd7) && !full;
    fill_wr  = fill_en && !bit_valid && !full;
    pix_next = data_wr ? {shreg, bit_data} : '0;
    bank_oh  = BANKS'(1) << (pix_idx >> (ADDR_W + 1));
    // Even row: even column -> odd memory; odd row swaps the parity.
    odd_sel  = (pix_idx[0] == pix_idx[ROW_B]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pix_idx     <= '0;
      shreg       <= '0;
      bcnt        <= '0;
      oem_dataout <= '0;
      oem_addr    <= '0;
      odd_wr      <= '0;
      even_wr     <= '0;
      oem_finish  <= 1'b0;
    end else begin
      // Bits beyond TOTAL still advance the packer; only the write is dropped.
      if (bit_valid) begin
        shreg <= {shreg[5:0], bit_data};
        bcnt  <= bcnt + 3'd1;
      end
      odd_wr  <= '0;
      even_wr <= '0;
      if (data_wr || fill_wr) begin
        oem_dataout <= pix_next;
        oem_addr    <= pix_idx[ADDR_W:1];
        if (odd_sel) odd_wr  <= bank_oh;
        else         even_wr <= bank_oh;
        pix_idx <= pix_idx + P_W'(1);
      end
      if (fill_en && full) oem_finish <= 1'b1;
    end
  end

endmodule

// File: rtl/sti_dac_multibank.sv
// Serial-transmit front end: word handshake, frame building and bit shifter,
// feeding the multi-bank pixel router.
module sti_dac_multibank
  import sti_dac_pkg::*;
#(
  parameter int unsigned BANKS   = 4,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned ROW_PIX = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  sti_dac_multibank_if.slave    pi,
  output logic                  so_data,
  output logic                  so_valid,
  output logic [PIX_W-1:0]      oem_dataout,
  output logic [ADDR_W-1:0]     oem_addr,
  output logic [BANKS-1:0]      odd_wr,
  output logic [BANKS-1:0]      even_wr,
  output logic                  oem_finish
);

  sti_state_e  state;
  len_e        len_in;
  logic [31:0] frame_buf;
  logic [31:0] lsb_buf;
  logic [31:0] sr;
  logic [5:0]  flen_in;
  logic [5:0]  flen_q;
  logic [5:0]  cnt;
  logic        msb_q;
  logic        end_q;
  logic        pix_full;
  logic        pix_fill;

  always_comb begin
    len_in    = len_e'(pi.pi_length);
    frame_buf = '0;
    case (len_in)
      LEN8:  frame_buf = {pi.pi_low ? pi.pi_data[15:8] : pi.pi_data[7:0], 24'h0};
      LEN16: frame_buf = {pi.pi_data, 16'h0};
      LEN24: frame_buf = pi.pi_fill ? {pi.pi_data, 16'h0} : {8'h0, pi.pi_data, 8'h0};
      LEN32: frame_buf = pi.pi_fill ? {pi.pi_data, 16'h0} : {16'h0, pi.pi_data};
      default: frame_buf = '0;
    endcase
    flen_in  = frame_len(pi.pi_length);
    // LSB-first frames are right-aligned so both orders shift from a fixed end.
    lsb_buf  = frame_buf >> (6'd32 - flen_in);
    pix_fill = (state == ST_FILL) || (state == ST_FIN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      pi.pi_ready <= 1'b1;
      so_data     <= 1'b0;
      so_valid    <= 1'b0;
      sr          <= '0;
      cnt         <= '0;
      flen_q      <= '0;
      msb_q       <= 1'b0;
      end_q       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pi.load) begin
            state       <= ST_SHIFT;
            pi.pi_ready <= 1'b0;
            so_valid    <= 1'b1;
            cnt         <= 6'd1;
            flen_q      <= flen_in;
            msb_q       <= pi.pi_msb;
            end_q       <= pi.pi_end;
            if (pi.pi_msb) begin
              so_data <= frame_buf[31];
              sr      <= {frame_buf[30:0], 1'b0};
            end else begin
              so_data <= lsb_buf[0];
              sr      <= {1'b0, lsb_buf[31:1]};
            end
          end
        end
        ST_SHIFT: begin
          if (cnt == flen_q) begin
            so_valid <= 1'b0;
            so_data  <= 1'b0;
            if (end_q) begin
              state <= pix_full ? ST_FIN : ST_FILL;
            end else begin
              state       <= ST_IDLE;
              pi.pi_ready <= 1'b1;
            end
          end else begin
            cnt <= cnt + 6'd1;
            if (msb_q) begin
              so_data <= sr[31];
              sr      <= {sr[30:0], 1'b0};
            end else begin
              so_data <= sr[0];
              sr      <= {1'b0, sr[31:1]};
            end
          end
        end
        ST_FILL: begin
          if (pix_full) state <= ST_FIN;
        end
        ST_FIN: begin
          state <= ST_FIN;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  oem_pixel_router #(
    .BANKS   (BANKS),
    .ADDR_W  (ADDR_W),
    .ROW_PIX (ROW_PIX)
  ) u_router (
    .clk         (clk),
    .reset       (reset),
    .bit_valid   (so_valid),
    .bit_data    (so_data),
    .fill_en     (pix_fill),
    .oem_dataout (oem_dataout),
    .oem_addr    (oem_addr),
    .odd_wr      (odd_wr),
    .even_wr     (even_wr),
    .oem_finish  (oem_finish),
    .full        (pix_full)
  );

endmodule

// File: tb/tb_sti_dac_multibank.sv
// Bench for sti_dac_multibank: framing vectors, serial capture, pixel scoreboard
// with cycle-exact strobe timing, zero-fill, mid-frame reset and overflow discard.
module tb_sti_dac_multibank;
  import sti_dac_pkg::*;

  localparam int unsigned BANKS   = 4;
  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned ROW_PIX = 8;
  localparam int          TOTAL   = BANKS * (1 << (ADDR_W + 1));

  logic              clk = 1'b0;
  logic              reset;
  logic              so_data;
  logic              so_valid;
  logic [7:0]        oem_dataout;
  logic [ADDR_W-1:0] oem_addr;
  logic [BANKS-1:0]  odd_wr;
  logic [BANKS-1:0]  even_wr;
  logic              oem_finish;

  sti_dac_multibank_if pi_bus ();

  sti_dac_multibank #(
    .BANKS   (BANKS),
    .ADDR_W  (ADDR_W),
    .ROW_PIX (ROW_PIX)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pi          (pi_bus),
    .so_data     (so_data),
    .so_valid    (so_valid),
    .oem_dataout (oem_dataout),
    .oem_addr    (oem_addr),
    .odd_wr      (odd_wr),
    .even_wr     (even_wr),
    .oem_finish  (oem_finish)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]  len;
    logic        fill;
    logic        msb;
    logic        low;
    logic [15:0] data;
    logic [31:0] exp_bits;
  } vec_t;

  typedef struct {
    logic [7:0]        d;
    logic [ADDR_W-1:0] a;
    logic [BANKS-1:0]  o;
    logic [BANKS-1:0]  e;
    int                cyc;
  } pix_t;

  int   nchecks  = 0;
  int   nerrors  = 0;
  int   mp       = 0;
  int   last_exp = 0;
  pix_t sb[$];
  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Routing model written from the pixel-index arithmetic (div/mod form).
  task automatic push_pix(input logic [7:0] d, input int at);
    pix_t e;
    int bank, r, k;
    if (mp >= TOTAL) return;
    bank  = mp / (2 * (1 << ADDR_W));
    r     = mp / ROW_PIX;
    k     = mp % ROW_PIX;
    e.d   = d;
    e.a   = ADDR_W'((mp / 2) % (1 << ADDR_W));
    e.o   = '0;
    e.e   = '0;
    if ((r % 2) == (k % 2)) e.o = BANKS'(1) << bank;
    else                    e.e = BANKS'(1) << bank;
    e.cyc = at;
    sb.push_back(e);
    last_exp = at;
    mp++;
  endtask

  always @(negedge clk) begin
    if (reset && ((|odd_wr) || (|even_wr))) begin
      pix_t e;
      if (sb.size() == 0) begin
        nchecks++;
        nerrors++;
        $display("FAIL unexpected_write: got odd %b even %b addr %0d data %h, expected no write",
                 odd_wr, even_wr, oem_addr, oem_dataout);
      end else begin
        e = sb.pop_front();
        check("pixel", {odd_wr, even_wr, oem_addr, oem_dataout}, {e.o, e.e, e.a, e.d});
        check("pixel_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!pi_bus.pi_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!pi_bus.pi_ready) check("ready_timeout", pi_bus.pi_ready, 1);
  endtask

  task automatic drive(input logic [1:0] len, input logic fill, msb, low, last, input logic [15:0] data);
    pi_bus.load      = 1'b1;
    pi_bus.pi_length = len;
    pi_bus.pi_fill   = fill;
    pi_bus.pi_msb    = msb;
    pi_bus.pi_low    = low;
    pi_bus.pi_end    = last;
    pi_bus.pi_data   = data;
  endtask

  task automatic send(input logic [1:0] len, input logic fill, msb, low, last,
                      input logic [15:0] data, input logic [31:0] exp_bits, input string name);
    int L, acc, vcnt;
    logic [31:0] got;
    L = (int'(len) + 1) * 8;
    wait_ready();
    drive(len, fill, msb, low, last, data);
    acc = cyc + 1;
    for (int j = 0; j < L / 8; j++) push_pix(exp_bits[31 - 8*j -: 8], acc + 8*j + 8);
    if (last) begin
      for (int f = 0; mp < TOTAL; f++) push_pix(8'h00, acc + L + 1 + f);
    end
    @(posedge clk);
    #1 pi_bus.load = 1'b0;
    got  = '0;
    vcnt = 0;
    for (int i = 0; i < L; i++) begin
      @(negedge clk);
      vcnt += so_valid ? 1 : 0;
      got = {got[30:0], so_data};
    end
    got = got << (32 - L);
    check({"serial_", name}, got, exp_bits);
    check({"valid_len_", name}, 64'(vcnt), 64'(L));
    @(negedge clk);
    check({"idle_valid_", name}, so_valid, 0);
    check({"ready_after_", name}, pi_bus.pi_ready, !last);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  logic [15:0] d;

  initial begin
    vecs[0] = '{2'd1, 1'b0, 1'b1, 1'b0, 16'hA55A, 32'hA55A0000};
    vecs[1] = '{2'd0, 1'b0, 1'b0, 1'b1, 16'h8100, 32'h81000000};
    vecs[2] = '{2'd2, 1'b0, 1'b1, 1'b0, 16'h1234, 32'h00123400};
    vecs[3] = '{2'd2, 1'b1, 1'b1, 1'b0, 16'h1234, 32'h12340000};
    vecs[4] = '{2'd3, 1'b0, 1'b0, 1'b0, 16'hC3A1, 32'h85C30000};
    vecs[5] = '{2'd0, 1'b0, 1'b1, 1'b0, 16'h12F0, 32'hF0000000};
    vecs[6] = '{2'd1, 1'b0, 1'b0, 1'b0, 16'h0001, 32'h80000000};
    vecs[7] = '{2'd3, 1'b1, 1'b1, 1'b0, 16'hBEEF, 32'hBEEF0000};
    vecs[8] = '{2'd0, 1'b1, 1'b1, 1'b1, 16'h5A00, 32'h5A000000};

    reset = 1'b0;
    drive(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    pi_bus.load = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ready", pi_bus.pi_ready, 1);
    check("reset_outputs", {so_data, so_valid, oem_dataout, oem_addr, odd_wr, even_wr, oem_finish}, 0);
    reset = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 9; v++)
      send(vecs[v].len, vecs[v].fill, vecs[v].msb, vecs[v].low, 1'b0,
           vecs[v].data, vecs[v].exp_bits, $sformatf("vec%0d", v));
    repeat (3) @(negedge clk);
    check("sb_drained_table", 64'(sb.size()), 0);

    // Reset while bit 5 of a frame is on the line.
    drive(2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFF);
    @(posedge clk);
    #1 pi_bus.load = 1'b0;
    repeat (5) @(negedge clk);
    check("bit5_valid", so_valid, 1);
    reset = 1'b0;
    #1;
    check("midreset_outputs", {so_data, so_valid, oem_dataout, oem_addr, odd_wr, even_wr, oem_finish}, 0);
    check("midreset_ready", pi_bus.pi_ready, 1);
    sb.delete();
    mp = 0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("release_ready", pi_bus.pi_ready, 1);

    // Two words, the second with pi_end: 4 data pixels then 252 zero fills.
    send(2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 16'hA55A, 32'hA55A0000, "end_w0");
    send(2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h00FF, 32'hFF000000, "end_w1");
    for (int n = 0; n < 400 && !oem_finish; n++) begin
      if (cyc == last_exp)
        check("last_fill_slot", {odd_wr, even_wr, oem_addr}, {4'b1000, 4'b0000, 5'd31});
      @(negedge clk);
    end
    check("finish_set", oem_finish, 1);
    check("finish_cycle", 64'(cyc), 64'(last_exp + 1));
    check("sb_drained_fill", 64'(sb.size()), 0);

    drive(2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h1234);
    repeat (6) begin
      @(negedge clk);
      check("fin_ready", pi_bus.pi_ready, 0);
      check("fin_valid", so_valid, 0);
      check("fin_sticky", oem_finish, 1);
    end
    pi_bus.load = 1'b0;

    // Fill all pixel space, overflow one word, then end with p already at TOTAL.
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    sb.delete();
    mp = 0;
    @(negedge clk);
    for (int w = 0; w < 64; w++) begin
      d = 16'(w * 37 + 5);
      send(2'd3, 1'b0, 1'b1, 1'b0, 1'b0, d, {16'h0, d}, "fillup");
    end
    send(2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 16'hC0DE, 32'hC0DE0000, "discard");
    send(2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h00AA, 32'hAA000000, "end_full");
    for (int n = 0; n < 10 && !oem_finish; n++) @(negedge clk);
    check("finish_direct", oem_finish, 1);
    check("sb_drained_overflow", 64'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule

// File: doc/sti_dac_multibank.md
# sti_dac_multibank

Parametrised successor of the serial-transmit / DAC-memory block. It accepts parallel words through a ready/load handshake and frames each word to 8/16/24/32 bits by the fill/low rules. It shifts the frame out MSB- or LSB-first on `so_data`/`so_valid`, regroups the bits into 8-bit pixels and writes them checkerboard-interleaved into `BANKS` odd/even memory pairs. On `pi_end` it zero-fills the remaining pixel space and raises `oem_finish`.

## Interface
Parameters:
- `BANKS`, 4: odd/even memory pairs, power of two, 1..8
- `ADDR_W`, 5: address width per memory, depth 2^ADDR_W
- `ROW_PIX`, 8: pixels per image row, power of two ≥2, sets checkerboard period

Ports:
- `clk`  in  1  the single clock; all logic on rising edge
- `reset`  in  1  asynchronous, active-low; assert anytime, release synchronised by the system
- `load`  in  1  pi_* valid; accepted on an edge where `load & pi_ready`
- `pi_ready`  out  1  block can accept a word
- `pi_data`  in  16  payload
- `pi_length`  in  2  frame length L = 8·(pi_length+1)
- `pi_fill`, `pi_msb`, `pi_low`, `pi_end`  in  1 each  framing / order / byte-select / last-word flags, sampled at acceptance
- `so_data`, `so_valid`  out  1 each  serial stream
- `oem_dataout`  out  8  pixel to memory
- `oem_addr`  out  ADDR_W  memory address
- `odd_wr`, `even_wr`  out  BANKS each  one-hot write strobes, bit b = bank b
- `oem_finish`  out  1  all pixels written; sticky until reset

## Operation
- 32-bit buffer B built at acceptance:
  - L8: {pi_low ? data[15:8] : data[7:0], 24'0}
  - L16: {data, 16'0}
  - L24: pi_fill ? {data, 16'0} : {8'0, data, 8'0}
  - L32: pi_fill ? {data, 16'0} : {16'0, data}
- Frame = B[31:32−L]. pi_msb=1 sends B[31] first, descending. pi_msb=0 sends B[32−L] first, ascending.
- STI FSM:
  - IDLE (pi_ready=1) → SHIFT on acceptance.
  - SHIFT counts L bits.
  - After the last bit: → IDLE, or → FILL if the word carried pi_end.
  - FILL → FIN when pixel count = TOTAL = BANKS·2^(ADDR_W+1).
  - FIN: pi_ready=0, load ignored.
- Pixel packer: each so_valid bit shifts into byte register from LSB; first bit of every 8 ends in bit 7. Global pixel index p starts at 0.
- Pixel p routing:
  - bank = p >> (ADDR_W+1)
  - oem_addr = (p>>1) mod 2^ADDR_W
  - row r = p/ROW_PIX, k = p mod ROW_PIX
  - r even: k even→odd_wr, k odd→even_wr; r odd: swapped
- p ≥ TOTAL before pi_end: pixels discarded, no strobes; serial side unaffected.
- FILL writes zero pixels at consecutive p, one per cycle. pi_end with p already = TOTAL → FIN directly.
- load while pi_ready=0 ignored, no side effects.

## Timing
- Acceptance edge k: so_valid=1 cycles k+1..k+L exactly, so_data valid with it. pi_ready=0 cycles k+1..k+L, 1 at k+L+1; back-to-back words have one idle cycle.
- Pixel whose 8th bit is on so_valid cycle c: strobe, oem_dataout, oem_addr all valid in cycle c+1 for one cycle.
- FILL strobes start the cycle after the final data strobe slot (c+1 of last bit). oem_finish rises the cycle after the last strobe, held until reset.
- Reset values: pi_ready 1, so_data 0, so_valid 0, oem_dataout 0, oem_addr 0, all wr 0, oem_finish 0, p 0, state IDLE.
- Mid-operation reset: frame and partial pixel discarded; writes restart at p=0.

## Structure
- Package `sti_dac_pkg`: pi_length encodings, FSM state enum, `frame_len()` function, pixel-width constant 8.
- Sub-module `oem_pixel_router`: packer, p counter, bank/addr/parity decode, FILL write generation, finish flag. The top holds handshake, framing and shifter.

## Test plan
Default parameters, acceptance at edge k.
- L16, msb, 16'hA55A → so_data 1010010101011010 over k+1..k+16. 0xA5 on odd_wr[0] addr0 at k+9. 0x5A on even_wr[0] addr0 at k+17.
- L8, pi_low=1, lsb, 16'h8100 → bits 1,0,0,0,0,0,0,1. Pixel 0x81 on odd_wr[0] addr0. pi_ready back at k+9.
- L24, msb, 16'h1234: fill=0 → pixels 00,12,34; fill=1 → pixels 12,34,00.
- 16 pixels → p0–7: odd,even alternating, addr 0,0,1,1,2,2,3,3. p8–15: even,odd alternating, addr 4..7.
- pi_end on second L16 word (4 pixels) → 252 zero-pixel strobes on consecutive cycles. Last is odd_wr[3] addr31. oem_finish next cycle; later load ignored.
- reset low during bit 5 of a frame → all outputs 0 immediately. After release pi_ready=1 and the next pixel goes to odd_wr[0] addr0.
